// File: rtl/ctl_trigger.sv
// Light-gun trigger conditioning: two-flop synchroniser, debounce FSM with one
// shared saturating counter, single-cycle shot/dry-fire pulses and a release cooldown.
module ctl_trigger #(
    parameter int DEBOUNCE_CYCLES = 650_000,
    parameter int COOLDOWN_CYCLES = 13_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reset_score,
    input  logic trigger_raw,
    input  logic no_ammo,
    output logic shot_fired,
    output logic dry_fire,
    output logic trigger_ready
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ? DEBOUNCE_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_HELD,
        S_RELEASE,
        S_COOLDOWN
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             sync_meta_reg, trig_s_reg;
    logic             shot_fired_reg, dry_fire_reg, trigger_ready_reg;
    logic             counting;

    // The synchroniser is deliberately untouched by reset_score so a held
    // trigger is still seen (and re-armed) after a round restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta_reg <= 1'b0;
            trig_s_reg    <= 1'b0;
        end else begin
            sync_meta_reg <= trigger_raw;
            trig_s_reg    <= sync_meta_reg;
        end
    end

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        counting   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (trig_s_reg) state_next = S_ARM;
            end
            S_ARM: begin
                counting = 1'b1;
                if (!trig_s_reg)               state_next = S_IDLE;
                else if (cnt_reg == DEB_LAST)  state_next = S_FIRE;
            end
            S_FIRE: begin
                state_next = S_HELD;
            end
            S_HELD: begin
                if (!trig_s_reg) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                counting = 1'b1;
                if (trig_s_reg)                state_next = S_HELD;
                else if (cnt_reg == DEB_LAST)  state_next = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                counting = 1'b1;
                if (cnt_reg == COOL_LAST) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (reset_score) state_next = S_IDLE;

        if (reset_score || (state_next != state_reg)) cnt_next = '0;
        else if (counting)                            cnt_next = cnt_inc;
        else                                          cnt_next = cnt_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= S_IDLE;
            cnt_reg           <= '0;
            shot_fired_reg    <= 1'b0;
            dry_fire_reg      <= 1'b0;
            trigger_ready_reg <= 1'b1;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            // no_ammo is sampled on the very edge that enters FIRE
            shot_fired_reg    <= (state_next == S_FIRE) && !no_ammo;
            dry_fire_reg      <= (state_next == S_FIRE) &&  no_ammo;
            trigger_ready_reg <= (state_next == S_IDLE);
        end
    end

    assign shot_fired    = shot_fired_reg;
    assign dry_fire      = dry_fire_reg;
    assign trigger_ready = trigger_ready_reg;

endmodule

// File: tb/tb_ctl_trigger.sv
// Self-checking bench for ctl_trigger (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8):
// expected pulses are queued with their edge number and matched as they appear.
module tb_ctl_trigger;

    logic clk = 1'b0;
    logic rst, reset_score, trigger_raw, no_ammo_drv, no_ammo;
    logic shot_fired, dry_fire, trigger_ready;

    typedef struct {
        bit dry;
        int cyc;
    } pulse_t;

    pulse_t exp_q[$];
    int     edge_cnt = 0;
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     ammo_en  = 1'b0;
    int     ammo_cnt = 3;

    always #5 clk = ~clk;

    ctl_trigger #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .reset_score  (reset_score),
        .trigger_raw  (trigger_raw),
        .no_ammo      (no_ammo),
        .shot_fired   (shot_fired),
        .dry_fire     (dry_fire),
        .trigger_ready(trigger_ready)
    );

    // Reference ammo counter used for the integration scenario
    assign no_ammo = ammo_en ? (ammo_cnt == 0) : no_ammo_drv;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (ammo_en && shot_fired && ammo_cnt > 0) ammo_cnt <= ammo_cnt - 1;
    end

    // Scoreboard: every pulse seen must match the head of the expected queue
    always @(negedge clk) begin
        if (shot_fired || dry_fire) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got shot=%b dry=%b at edge %0d, required no pulse",
                         shot_fired, dry_fire, edge_cnt);
            end else begin
                pulse_t e;
                e = exp_q.pop_front();
                if (shot_fired && dry_fire || dry_fire !== e.dry || edge_cnt != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse_match: got shot=%b dry=%b at edge %0d, required dry=%0d at edge %0d",
                             shot_fired, dry_fire, edge_cnt, e.dry, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic goto_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic pull(input bit dry);
        int e0;
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{dry, e0 + 7});
        goto_edge(e0 + 10);
        trigger_raw = 1'b0;
        goto_edge(e0 + 26);
    endtask

    task automatic test_reset();
        rst = 1'b0; reset_score = 1'b0; trigger_raw = 1'b0; no_ammo_drv = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (shot_fired !== 1'b0 || dry_fire !== 1'b0 || trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: got shot=%b dry=%b ready=%b, required 0 0 1",
                     shot_fired, dry_fire, trigger_ready);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b, required 1", trigger_ready);
        end
    endtask

    task automatic test_clean_press();
        int e0, r;
        bit exp_rdy;
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b0, e0 + 7});
        for (int k = 1; k <= 9; k++) begin
            goto_edge(e0 + k);
            exp_rdy = (k < 3);
            n_checks++;
            if (trigger_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL press_ready_k%0d: got %b, required %b", k, trigger_ready, exp_rdy);
            end
        end
        goto_edge(e0 + 12);
        r = edge_cnt;
        trigger_raw = 1'b0;
        goto_edge(r + 14);
        n_checks++;
        if (trigger_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cooldown_last_ready: got %b, required 0", trigger_ready);
        end
        goto_edge(r + 15);
        n_checks++;
        if (trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cooldown_end_ready: got %b, required 1", trigger_ready);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL press_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        int s, e0, r;
        for (int i = 0; i < 5; i++) begin
            s = edge_cnt;
            trigger_raw = 1'b1;
            goto_edge(s + 2);
            trigger_raw = 1'b0;
            goto_edge(s + 6);
            n_checks++;
            if (trigger_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL glitch_idle_%0d: got ready=%b, required 1", i, trigger_ready);
            end
        end
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b0, e0 + 7});
        goto_edge(e0 + 10);
        for (int i = 0; i < 3; i++) begin
            trigger_raw = 1'b0;
            repeat (2) @(negedge clk);
            trigger_raw = 1'b1;
            repeat (3) @(negedge clk);
        end
        r = edge_cnt;
        trigger_raw = 1'b0;
        goto_edge(r + 16);
        n_checks++;
        if (trigger_ready !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_end: got ready=%b pending=%0d, required ready=1 pending=0",
                     trigger_ready, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_hold_repull();
        int e0, r;
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b0, e0 + 7});
        goto_edge(e0 + 50);
        r = edge_cnt;
        trigger_raw = 1'b0;
        goto_edge(r + 10);
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b0, r + 20});
        goto_edge(r + 15);
        n_checks++;
        if (trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL repull_idle: got ready=%b, required 1", trigger_ready);
        end
        goto_edge(r + 16);
        n_checks++;
        if (trigger_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL repull_arm: got ready=%b, required 0", trigger_ready);
        end
        goto_edge(r + 24);
        trigger_raw = 1'b0;
        goto_edge(r + 40);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL repull_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_empty_mag();
        int e0;
        no_ammo_drv = 1'b1;
        pull(1'b1);
        // no_ammo rises on the FIRE-entry edge itself: dry fire
        no_ammo_drv = 1'b0;
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b1, e0 + 7});
        goto_edge(e0 + 6);
        no_ammo_drv = 1'b1;
        goto_edge(e0 + 10);
        trigger_raw = 1'b0;
        goto_edge(e0 + 26);
        // no_ammo rises one edge too late: still a real shot
        no_ammo_drv = 1'b0;
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b0, e0 + 7});
        goto_edge(e0 + 7);
        no_ammo_drv = 1'b1;
        goto_edge(e0 + 10);
        trigger_raw = 1'b0;
        goto_edge(e0 + 26);
        no_ammo_drv = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL empty_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ammo_integration();
        int exp_cnt;
        ammo_cnt = 3;
        ammo_en  = 1'b1;
        for (int p = 0; p < 5; p++) begin
            pull(p >= 3);
            exp_cnt = (p < 3) ? 2 - p : 0;
            n_checks++;
            if (ammo_cnt != exp_cnt || no_ammo !== (exp_cnt == 0)) begin
                n_fail++;
                $display("FAIL ammo_pull%0d: got count=%0d no_ammo=%b, required count=%0d no_ammo=%b",
                         p + 1, ammo_cnt, no_ammo, exp_cnt, exp_cnt == 0);
            end
        end
        ammo_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ammo_missing: got %0d pending pulses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_resets();
        int e0, r;
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        goto_edge(e0 + 4);
        reset_score = 1'b1;
        goto_edge(e0 + 5);
        reset_score = 1'b0;
        n_checks++;
        if (trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL score_arm_idle: got ready=%b, required 1", trigger_ready);
        end
        exp_q.push_back('{1'b0, e0 + 10});
        goto_edge(e0 + 6);
        n_checks++;
        if (trigger_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL score_rearm: got ready=%b, required 0", trigger_ready);
        end
        goto_edge(e0 + 13);
        r = edge_cnt;
        trigger_raw = 1'b0;
        goto_edge(r + 9);
        reset_score = 1'b1;
        goto_edge(r + 10);
        reset_score = 1'b0;
        n_checks++;
        if (trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL score_cooldown_idle: got ready=%b, required 1", trigger_ready);
        end
        goto_edge(r + 12);
        n_checks++;
        if (trigger_ready !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL score_cooldown_stay: got ready=%b pending=%0d, required 1 0",
                     trigger_ready, exp_q.size());
            exp_q.delete();
        end
        // Asynchronous reset in the middle of a shot pulse
        e0 = edge_cnt;
        trigger_raw = 1'b1;
        exp_q.push_back('{1'b0, e0 + 7});
        goto_edge(e0 + 7);
        #1;
        n_checks++;
        if (shot_fired !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_pulse: got shot=%b, required 1", shot_fired);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (shot_fired !== 1'b0 || dry_fire !== 1'b0 || trigger_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: got shot=%b dry=%b ready=%b, required 0 0 1",
                     shot_fired, dry_fire, trigger_ready);
        end
        trigger_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (trigger_ready !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_after: got ready=%b pending=%0d, required 1 0",
                     trigger_ready, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repull();
        test_empty_mag();
        test_ammo_integration();
        test_resets();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
